// File: rtl/seq_divider_4x4_pkg.sv
// Shared Arithmetic Unit definitions: operand width and the divider FSM state encoding.
package au_pkg;

    localparam int AU_WIDTH = 4;

    typedef logic [1:0] au_state_t;

    localparam au_state_t ST_IDLE = 2'b00;
    localparam au_state_t ST_CALC = 2'b01;
    localparam au_state_t ST_FIN  = 2'b10;

endpackage

// File: rtl/seq_divider_4x4_if.sv
// Request/result bundle between an AU client (master) and the sequential divider (slave).
interface seq_divider_4x4_if
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH
);

    // Handshake: start is sampled only while the divider is idle (busy=0, done=0);
    // dividend/divisor are captured on that accepting edge. done pulses for one cycle
    // when quotient/remainder/div_by_zero update; those results then hold until the
    // next completion. state mirrors the FSM register for observation.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    au_state_t        state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, state
    );

endinterface

// File: rtl/seq_divider_4x4_trial_sub.sv
// Trial subtractor for one restoring-division step: a ripple of full adders computing
// a + ~b + 1, with borrow = ~carry_out telling the caller to restore.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    logic [W:0]   w_carry;
    logic [W-1:0] w_b_n;

    assign w_b_n      = ~i_b;
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[gi]),
            .i_b    (w_b_n[gi]),
            .i_cin  (w_carry[gi]),
            .o_sum  (o_diff[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    assign o_borrow = ~w_carry[W];

endmodule

// File: rtl/seq_divider_4x4.sv
// Sequential restoring divider: one quotient bit per clock, IDLE -> CALC x WIDTH -> FIN.
// Divide-by-zero skips CALC and reports all-ones quotient with the dividend as remainder.
module seq_divider_4x4
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH,
    parameter int CNT_W = 2            // 2**CNT_W must cover WIDTH iterations
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_4x4_if.slave   bus
);

    au_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_unused_r_msb;

    // Partial remainder is always below the divisor, so its top bit never feeds the shift.
    assign w_shift        = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_unused_r_msb = r_r[WIDTH];

    div_trial_sub #(
        .W (WIDTH + 1)
    ) u_trial (
        .i_a      (w_shift),
        .i_b      ({1'b0, r_dvsr}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_r_next = w_borrow ? w_shift : w_diff;
    assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_dvsr      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dvsr <= bus.divisor;
                        r_q    <= bus.dividend;
                        r_r    <= '0;
                        r_cnt  <= CNT_W'(WIDTH - 1);
                        if (bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_state     <= ST_FIN;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_state     <= ST_FIN;
                    end
                end
                ST_FIN:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == ST_CALC);
    assign bus.done        = (r_state == ST_FIN);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_seq_divider_4x4.sv
// Directed bench for seq_divider_4x4: a cycle-level model built from the latency and
// arithmetic rules is compared with the DUT every cycle, plus literal spot checks.
module tb_seq_divider_4x4;

    logic clk;
    logic rst_n;

    seq_divider_4x4_if #(.WIDTH(4)) bus ();

    seq_divider_4x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_busy_left = 0;   // busy cycles still owed to the current divide
    bit         m_done      = 1'b0;
    int         m_accepts   = 0;
    logic [3:0] m_a = '0, m_b = '0;
    logic [3:0] e_q = '0, e_r = '0;
    logic       e_dbz = 1'b0;
    int         busy_run     = 0;
    int         dut_done_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_left = 0;
            m_done      = 1'b0;
            e_q         = '0;
            e_r         = '0;
            e_dbz       = 1'b0;
            busy_run    = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_done = 1'b1;
                e_q    = m_a / m_b;
                e_r    = m_a % m_b;
                e_dbz  = 1'b0;
            end
        end else if (bus.start) begin
            m_accepts++;
            m_a = bus.dividend;
            m_b = bus.divisor;
            if (m_b == 4'd0) begin
                m_done = 1'b1;
                e_q    = 4'hF;
                e_r    = m_a;
                e_dbz  = 1'b1;
            end else begin
                m_busy_left = 4;
            end
        end
        #1;
        if (check_en) begin
            chk("busy",        32'(bus.busy),        32'(m_busy_left > 0));
            chk("done",        32'(bus.done),        32'(m_done));
            chk("quotient",    32'(bus.quotient),    32'(e_q));
            chk("remainder",   32'(bus.remainder),   32'(e_r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(e_dbz));
            if (bus.busy) busy_run++;
            if (bus.done) begin
                dut_done_cnt++;
                chk("busy_len", 32'(busy_run), (m_b == 4'd0) ? 32'd0 : 32'd4);
                busy_run = 0;
                if (m_b != 4'd0)
                    chk("invariant",
                        32'((int'(bus.quotient) * int'(m_b) + int'(bus.remainder) == int'(m_a))
                            && (bus.remainder < m_b)), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        int acc0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        acc0 = m_accepts;
        for (int i = 0; i < 12 && m_accepts == acc0; i++) @(negedge clk);
        if (m_accepts == acc0) chk("accept_timeout", 32'd0, 32'd1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!m_done && i < 12) begin
            @(negedge clk);
            i++;
        end
        if (!m_done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_result(input string name, input logic [3:0] q, input logic [3:0] r,
                              input logic dbz);
        chk({name, "_q"},   32'(bus.quotient),    32'(q));
        chk({name, "_r"},   32'(bus.remainder),   32'(r));
        chk({name, "_dbz"}, 32'(bus.div_by_zero), 32'(dbz));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int d0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk_result("rst", 4'd0, 4'd0, 1'b0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        issue(4'd13, 4'd3);
        wait_done();
        chk("done_13_3", 32'(bus.done), 32'd1);
        chk_result("div_13_3", 4'd4, 4'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk_result("hold_13_3", 4'd4, 4'd1, 1'b0);

        issue(4'd15, 4'd1); wait_done(); chk_result("div_15_1", 4'd15, 4'd0, 1'b0);
        issue(4'd5,  4'd7); wait_done(); chk_result("div_5_7",  4'd0,  4'd5, 1'b0);
        issue(4'd0,  4'd9); wait_done(); chk_result("div_0_9",  4'd0,  4'd0, 1'b0);

        issue(4'd9, 4'd0);
        wait_done();
        chk("dbz_busy", 32'(bus.busy), 32'd0);
        chk_result("div_9_0", 4'hF, 4'd9, 1'b1);
        issue(4'd8, 4'd2); wait_done(); chk_result("div_8_2", 4'd4, 4'd0, 1'b0);

        // start pulses with new operands during CALC must be ignored
        d0 = dut_done_cnt;
        issue(4'd12, 4'd5);
        for (int i = 0; i < 4; i++) begin
            bus.start    = 1'b1;
            bus.dividend = 4'd15;
            bus.divisor  = 4'd15;
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done();
        chk_result("div_12_5", 4'd2, 4'd2, 1'b0);
        repeat (4) @(negedge clk);
        chk("done_pulses_12_5", 32'(dut_done_cnt - d0), 32'd1);

        // asynchronous reset in the second CALC cycle
        issue(4'd14, 4'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk_result("midrst", 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd14, 4'd3); wait_done(); chk_result("div_14_3", 4'd4, 4'd2, 1'b0);

        // back-to-back sweep at earliest legal accept
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue(4'(a), 4'(b));
        wait_done();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
